// File: rtl/i2c_host_pkg.sv
// Shared constants for the I2C host sequencer: register map, SR bit positions,
// CTR command bytes, response error codes and the sequencing FSM states.
package i2c_host_pkg;

    localparam logic [7:0] REG_RR   = 8'h00;
    localparam logic [7:0] REG_PRER = 8'h02;
    localparam logic [7:0] REG_CTR  = 8'h04;
    localparam logic [7:0] REG_SR   = 8'h08;
    localparam logic [7:0] REG_TO   = 8'h0A;
    localparam logic [7:0] REG_DR   = 8'h0E;

    localparam int SR_ARB_LOST = 4;
    localparam int SR_TIME_OUT = 3;
    localparam int SR_INTER    = 1;
    localparam int SR_ACK_REC  = 0;

    // CTR bytes: core_en|mode(|master_rw), plus inter_rst / ack where needed
    localparam logic [7:0] CTR_START_WR = 8'hA0;
    localparam logic [7:0] CTR_START_RD = 8'hB0;
    localparam logic [7:0] CTR_CLR_W    = 8'hA2;
    localparam logic [7:0] CTR_CLR_R    = 8'hBA;
    localparam logic [7:0] CTR_STOP     = 8'h82;

    localparam logic [1:0] ERR_OK      = 2'd0;
    localparam logic [1:0] ERR_NACK    = 2'd1;
    localparam logic [1:0] ERR_ARB     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [3:0] {
        ST_INIT_PRER,
        ST_INIT_TO,
        ST_IDLE,
        ST_LD_ADDR,
        ST_START,
        ST_WAIT_A,
        ST_LD_DATA,
        ST_CLR_W,
        ST_CLR_R,
        ST_WAIT_D,
        ST_RD_RR,
        ST_STOP,
        ST_ERR,
        ST_RESP
    } state_t;

endpackage

// File: rtl/i2c_host_sequencer_if.sv
// Client-side command/response handshake of the I2C host sequencer.
interface i2c_host_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rd;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic [1:0] rsp_err;

    modport master (
        output cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/i2c_reg_bus_cycle.sv
// One processor-interface register access: as, then ds, capture, gap, done pulse.
module i2c_reg_bus_cycle #(
    parameter int AS_CYCLES  = 3,
    parameter int DS_CYCLES  = 4,
    parameter int GAP_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req,
    input  logic       write,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic [7:0] add_bus,
    output logic [7:0] bus_wdata,
    input  logic [7:0] bus_rdata,
    output logic       as,
    output logic       ds,
    output logic       rw
);
    localparam int TOTAL = AS_CYCLES + DS_CYCLES + GAP_CYCLES;
    localparam int CW    = $clog2(TOTAL + 1);

    logic          busy_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_reg  <= 1'b0;
            cnt_reg   <= '0;
            done      <= 1'b0;
            rdata     <= '0;
            add_bus   <= '0;
            bus_wdata <= '0;
            as        <= 1'b0;
            ds        <= 1'b0;
            rw        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!busy_reg) begin
                if (req) begin
                    busy_reg  <= 1'b1;
                    cnt_reg   <= '0;
                    as        <= 1'b1;
                    add_bus   <= addr;
                    bus_wdata <= wdata;
                    rw        <= write;
                end
            end else begin
                // cnt_reg is the index of the current clock within the frame
                cnt_reg <= cnt_reg + 1'b1;
                if (cnt_reg == CW'(AS_CYCLES - 1))
                    ds <= 1'b1;
                if (cnt_reg == CW'(AS_CYCLES + DS_CYCLES - 1)) begin
                    as    <= 1'b0;
                    ds    <= 1'b0;
                    rdata <= bus_rdata;
                end
                if (cnt_reg == CW'(TOTAL - 2))
                    done <= 1'b1;
                if (cnt_reg == CW'(TOTAL - 1))
                    busy_reg <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/i2c_host_sequencer.sv
// Autonomous host that turns single-byte client commands into I2C core
// register accesses (DR load, START, SR polling, data, STOP) and reports status.
module i2c_host_sequencer
    import i2c_host_pkg::*;
#(
    parameter logic [7:0]  PRESCALE    = 8'h10,
    parameter logic [7:0]  TIMEOUT_VAL = 8'h40,
    parameter int          AS_CYCLES   = 3,
    parameter int          DS_CYCLES   = 4,
    parameter int          GAP_CYCLES  = 2,
    parameter logic [15:0] POLL_LIMIT  = 16'd2000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    i2c_host_sequencer_if.slave  cmd_if,
    output logic [7:0]           add_bus,
    output logic [7:0]           bus_wdata,
    input  logic [7:0]           bus_rdata,
    output logic                 as,
    output logic                 ds,
    output logic                 rw,
    output logic                 init_done
);
    state_t      state_reg;
    logic        issued_reg;
    logic        req_reg;
    logic        cmd_rd_reg;
    logic [6:0]  cmd_addr_reg;
    logic [7:0]  cmd_wdata_reg;
    logic [15:0] poll_cnt_reg;
    logic        cmd_ready_reg;
    logic        rsp_valid_reg;
    logic [7:0]  rsp_rdata_reg;
    logic [1:0]  rsp_err_reg;
    logic        init_done_reg;

    logic        bus_done;
    logic [7:0]  bus_cycle_rdata;
    logic [7:0]  acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_write;

    // Register access implied by each state; latched by the bus cycle on req
    always_comb begin
        acc_addr  = REG_SR;
        acc_wdata = 8'h00;
        acc_write = 1'b0;
        case (state_reg)
            ST_INIT_PRER: begin acc_addr = REG_PRER; acc_wdata = PRESCALE;    acc_write = 1'b1; end
            ST_INIT_TO:   begin acc_addr = REG_TO;   acc_wdata = TIMEOUT_VAL; acc_write = 1'b1; end
            ST_LD_ADDR:   begin acc_addr = REG_DR;   acc_wdata = {cmd_addr_reg, cmd_rd_reg}; acc_write = 1'b1; end
            ST_START:     begin acc_addr = REG_CTR;  acc_wdata = cmd_rd_reg ? CTR_START_RD : CTR_START_WR; acc_write = 1'b1; end
            ST_LD_DATA:   begin acc_addr = REG_DR;   acc_wdata = cmd_wdata_reg; acc_write = 1'b1; end
            ST_CLR_W:     begin acc_addr = REG_CTR;  acc_wdata = CTR_CLR_W;   acc_write = 1'b1; end
            ST_CLR_R:     begin acc_addr = REG_CTR;  acc_wdata = CTR_CLR_R;   acc_write = 1'b1; end
            ST_STOP:      begin acc_addr = REG_CTR;  acc_wdata = CTR_STOP;    acc_write = 1'b1; end
            ST_RD_RR:     acc_addr = REG_RR;
            default:      ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_INIT_PRER;
            issued_reg    <= 1'b0;
            req_reg       <= 1'b0;
            cmd_rd_reg    <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            poll_cnt_reg  <= '0;
            cmd_ready_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= ERR_OK;
            init_done_reg <= 1'b0;
        end else begin
            req_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_if.cmd_valid && cmd_ready_reg) begin
                        cmd_rd_reg    <= cmd_if.cmd_rd;
                        cmd_addr_reg  <= cmd_if.cmd_addr;
                        cmd_wdata_reg <= cmd_if.cmd_wdata;
                        cmd_ready_reg <= 1'b0;
                        rsp_rdata_reg <= '0;
                        rsp_err_reg   <= ERR_OK;
                        state_reg     <= ST_LD_ADDR;
                    end
                end
                ST_ERR:
                    state_reg <= (rsp_err_reg == ERR_ARB) ? ST_RESP : ST_STOP;
                ST_RESP: begin
                    rsp_valid_reg <= 1'b1;
                    cmd_ready_reg <= 1'b1;
                    state_reg     <= ST_IDLE;
                end
                default: begin
                    if (!issued_reg) begin
                        req_reg    <= 1'b1;
                        issued_reg <= 1'b1;
                    end else if (bus_done) begin
                        issued_reg <= 1'b0;
                        case (state_reg)
                            ST_INIT_PRER: state_reg <= ST_INIT_TO;
                            ST_INIT_TO: begin
                                init_done_reg <= 1'b1;
                                cmd_ready_reg <= 1'b1;
                                state_reg     <= ST_IDLE;
                            end
                            ST_LD_ADDR:   state_reg <= ST_START;
                            ST_START: begin
                                poll_cnt_reg <= '0;
                                state_reg    <= ST_WAIT_A;
                            end
                            ST_LD_DATA:   state_reg <= ST_CLR_W;
                            ST_CLR_W, ST_CLR_R: begin
                                poll_cnt_reg <= '0;
                                state_reg    <= ST_WAIT_D;
                            end
                            ST_WAIT_A, ST_WAIT_D: begin
                                // arb_lost beats time_out beats inter on one sample
                                if (bus_cycle_rdata[SR_ARB_LOST]) begin
                                    rsp_err_reg <= ERR_ARB;
                                    state_reg   <= ST_ERR;
                                end else if (bus_cycle_rdata[SR_TIME_OUT]) begin
                                    rsp_err_reg <= ERR_TIMEOUT;
                                    state_reg   <= ST_ERR;
                                end else if (bus_cycle_rdata[SR_INTER]) begin
                                    if (bus_cycle_rdata[SR_ACK_REC] &&
                                        (state_reg == ST_WAIT_A || !cmd_rd_reg)) begin
                                        rsp_err_reg <= ERR_NACK;
                                        state_reg   <= ST_ERR;
                                    end else if (state_reg == ST_WAIT_A) begin
                                        state_reg <= cmd_rd_reg ? ST_CLR_R : ST_LD_DATA;
                                    end else begin
                                        state_reg <= cmd_rd_reg ? ST_RD_RR : ST_STOP;
                                    end
                                end else if (poll_cnt_reg == POLL_LIMIT - 16'd1) begin
                                    rsp_err_reg <= ERR_TIMEOUT;
                                    state_reg   <= ST_ERR;
                                end else begin
                                    poll_cnt_reg <= poll_cnt_reg + 16'd1;
                                end
                            end
                            ST_RD_RR: begin
                                rsp_rdata_reg <= bus_cycle_rdata;
                                state_reg     <= ST_STOP;
                            end
                            ST_STOP:      state_reg <= ST_RESP;
                            default:      state_reg <= ST_IDLE;
                        endcase
                    end
                end
            endcase
        end
    end

    assign cmd_if.cmd_ready = cmd_ready_reg;
    assign cmd_if.rsp_valid = rsp_valid_reg;
    assign cmd_if.rsp_rdata = rsp_rdata_reg;
    assign cmd_if.rsp_err   = rsp_err_reg;
    assign init_done        = init_done_reg;

    i2c_reg_bus_cycle #(
        .AS_CYCLES  (AS_CYCLES),
        .DS_CYCLES  (DS_CYCLES),
        .GAP_CYCLES (GAP_CYCLES)
    ) u_bus_cycle (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_reg),
        .write     (acc_write),
        .addr      (acc_addr),
        .wdata     (acc_wdata),
        .done      (bus_done),
        .rdata     (bus_cycle_rdata),
        .add_bus   (add_bus),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .as        (as),
        .ds        (ds),
        .rw        (rw)
    );
endmodule
